integer_source: RTL
===================

Name: integer_source

Overview:
- Transmit-side counterpart of the integer-typed sink testbench DUT.
- Drives one output of each SystemVerilog integer type (enum, byte, shortint, int, longint, integer) as a stream of stepped values under a valid/ready handshake.
- cocotb benches read these values back and check signed decoding, 2-state/4-state handling and enum decoding, all cycle-accurate.
- Sits as a standalone top-level DUT in the integer test cases.

Parameters:
- MAX_BEATS, 0, number of accepted beats before the source stops; 0 = unlimited.
- RESET_SEED, 0, longint value that all counters take at reset, truncated per width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  request to produce beats.
- load  input  1  reload all counters from seed this cycle.
- seed  input  64 (longint)  reload value.
- step  input  8 (byte, signed)  increment applied on each accepted beat.
- ready  input  1  sink accepts the current beat.
- valid  output  1  current outputs hold a beat.
- enum_output  output  enum_e  cycles A->B->C->D->A.
- byte_output  output  byte  counter.
- shortint_output  output  shortint  counter.
- int_output  output  int  counter.
- longint_output  output  longint  counter.
- integer_output  output  integer  counter, 4-state type, driven 2-state.
- beat_count  output  32  accepted beats since reset or load, wraps at 2^32.
- done  output  1  MAX_BEATS reached.

Behaviour:
- Reset: rst_n is asynchronous, active-low, and takes effect immediately.
  - All counters = RESET_SEED truncated to their width, interpreted signed.
  - enum_output = A; valid = 0; beat_count = 0; done = 0.
- valid rise: valid rises on the first posedge where enable=1 and done=0 are sampled. Outputs are already stable at that point.
- Handshake: a beat transfers on a posedge with valid=1 and ready=1.
  - While valid=1 and ready=0, all data outputs hold stable.
  - valid never drops without a transfer.
- Advance on transfer, effective next cycle:
  - Each counter += sign-extended step, wrapping modulo 2^width (two's complement, no saturation).
  - enum advances A->B->C->D->A, independent of step.
  - beat_count += 1.
- Back-to-back: with ready held at 1, one beat is transferred per cycle; there are no bubbles.
- Disable: if enable=0 at a transfer, valid = 0 next cycle and the counters still advance. valid re-rises on the first posedge that samples enable=1 again.
- Done: when beat_count reaches MAX_BEATS (MAX_BEATS != 0) on a transfer:
  - done = 1 and valid = 0 the next cycle.
  - done holds until load or reset.
- Load: has priority over advance.
  - All counters = seed truncated to width; enum = A; beat_count = 0; done = 0.
  - A transfer in the same cycle is still accepted by the sink but is not counted.
  - valid after load = enable.
- step = 0: values repeat; only enum and beat_count change.
- Reset mid-stall: valid drops asynchronously. No beat is considered transferred.

Decomposition:
- integers_pkg holds:
  - typedef enum_e {A, B, C=45, D=123789}, shared with the sink DUT;
  - function next_enum(enum_e) implementing the A->B->C->D->A sequence;
  - localparam widths 8/16/32/64.
- Sub-module int_step_counter #(WIDTH) holds one signed wrap counter with load/advance/step inputs. It is instantiated once for byte, shortint, int and longint. The integer counter reuses the WIDTH=32 instance type.
- FSM in top: IDLE (valid=0) -> ACTIVE (valid=1) -> DONE.
  - IDLE -> ACTIVE: enable=1 and not done.
  - ACTIVE -> IDLE: transfer with enable=0.
  - ACTIVE -> DONE: transfer with beat_count+1 == MAX_BEATS.
  - Any state -> IDLE or ACTIVE on load, per enable.

Test Plan:
- Reset, RESET_SEED=0 -> all counters 0, enum A, valid 0, beat_count 0. Then enable=1, ready=1, step=1 for 4 beats -> byte values 0,1,2,3; enum A,B,C(45),D(123789); beat_count 4.
- Signed wrap: load seed=126, step=1, ready=1 -> byte_output 126, 127, -128, -127. shortint/int/longint read 126, 127, 128, 129.
- Negative step and 64-bit wrap: load seed=-9223372036854775807, step=-2 -> longint_output wraps to 9223372036854775807; int_output, seeded with low 32 bits = 1, gives 1, -1, -3.
- Stall: ready=0 for 5 cycles with valid=1 -> all outputs and beat_count unchanged. ready=1 -> the next value appears on the following cycle.
- MAX_BEATS=3, ready=1 -> exactly 3 transfers, then valid=0 and done=1. load then clears done, and valid reasserts with enable=1.
- Load coincident with transfer, seed=100 -> next byte_output 100, enum A, beat_count 0. Assert rst_n=0 mid-stream -> valid drops asynchronously.

Source files
------------

// File: rtl/integers_pkg.sv
// rtl/integers_pkg.sv - shared integer-type widths, enum and FSM state types
package integers_pkg;

  localparam int BYTE_W     = 8;
  localparam int SHORTINT_W = 16;
  localparam int INT_W      = 32;
  localparam int LONGINT_W  = 64;

  // Sparse encodings so the sink exercises non-contiguous enum decoding.
  typedef enum int {
    A = 0,
    B = 1,
    C = 45,
    D = 123789
  } enum_e;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  function automatic enum_e next_enum(input enum_e cur);
    case (cur)
      A:       return B;
      B:       return C;
      C:       return D;
      default: return A;
    endcase
  endfunction

endpackage

// File: rtl/int_step_counter.sv
// rtl/int_step_counter.sv - signed wrap-around counter advanced by a signed byte step
module int_step_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    advance_i,
  input  logic [WIDTH-1:0]        seed_i,
  input  logic signed [7:0]       step_i,
  output logic signed [WIDTH-1:0] value_o
);

  logic signed [WIDTH-1:0] value_q;
  logic signed [WIDTH-1:0] value_d;
  logic signed [WIDTH-1:0] step_ext;

  // Size cast of a signed operand sign-extends; the add then wraps modulo 2^WIDTH.
  assign step_ext = WIDTH'(step_i);

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = seed_i;
    end else if (advance_i) begin
      value_d = value_q + step_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RESET_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/integer_source.sv
// rtl/integer_source.sv - valid/ready source of stepped values for every integer type
module integer_source
  import integers_pkg::*;
#(
  parameter int unsigned MAX_BEATS  = 0,
  parameter longint      RESET_SEED = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               load,
  input  logic [63:0]        seed,
  input  logic signed [7:0]  step,
  input  logic               ready,
  output logic               valid,
  output enum_e              enum_output,
  output byte                byte_output,
  output shortint            shortint_output,
  output int                 int_output,
  output longint             longint_output,
  output integer             integer_output,
  output logic [31:0]        beat_count,
  output logic               done
);

  state_e      state_q;
  logic        valid_q;
  logic        done_q;
  logic [31:0] beat_count_q;
  enum_e       enum_q;

  logic xfer;
  logic advance;
  logic last_beat;

  assign xfer      = valid_q & ready;
  assign advance   = xfer & ~load;
  assign last_beat = (MAX_BEATS != 0) && ((beat_count_q + 32'd1) == MAX_BEATS);

  int_step_counter #(.WIDTH(BYTE_W), .RESET_VALUE(RESET_SEED[BYTE_W-1:0])) u_byte_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (advance),
    .seed_i    (seed[BYTE_W-1:0]),
    .step_i    (step),
    .value_o   (byte_output)
  );

  int_step_counter #(.WIDTH(SHORTINT_W), .RESET_VALUE(RESET_SEED[SHORTINT_W-1:0])) u_shortint_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (advance),
    .seed_i    (seed[SHORTINT_W-1:0]),
    .step_i    (step),
    .value_o   (shortint_output)
  );

  int_step_counter #(.WIDTH(INT_W), .RESET_VALUE(RESET_SEED[INT_W-1:0])) u_int_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (advance),
    .seed_i    (seed[INT_W-1:0]),
    .step_i    (step),
    .value_o   (int_output)
  );

  int_step_counter #(.WIDTH(LONGINT_W), .RESET_VALUE(RESET_SEED)) u_longint_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (advance),
    .seed_i    (seed),
    .step_i    (step),
    .value_o   (longint_output)
  );

  // The 4-state integer port is fed from an ordinary 32-bit counter, so it never carries X/Z.
  int_step_counter #(.WIDTH(INT_W), .RESET_VALUE(RESET_SEED[INT_W-1:0])) u_integer_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .advance_i (advance),
    .seed_i    (seed[INT_W-1:0]),
    .step_i    (step),
    .value_o   (integer_output)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      beat_count_q <= '0;
      enum_q       <= A;
    end else if (load) begin
      // A beat accepted in the load cycle is dropped from the count.
      state_q      <= enable ? ACTIVE : IDLE;
      valid_q      <= enable;
      done_q       <= 1'b0;
      beat_count_q <= '0;
      enum_q       <= A;
    end else begin
      if (advance) begin
        beat_count_q <= beat_count_q + 32'd1;
        enum_q       <= next_enum(enum_q);
      end
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= ACTIVE;
            valid_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            if (last_beat) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (!enable) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid       = valid_q;
  assign done        = done_q;
  assign beat_count  = beat_count_q;
  assign enum_output = enum_q;

endmodule
